// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_pkg
//  Description : Shared definitions for the branch target buffer: 2-bit
//                direction counter encodings, the saturating counter step,
//                and PC index/tag extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    // Widest PC the helpers accept; callers zero-extend and truncate.
    localparam int MAX_XLEN = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // One step of a 2-bit saturating counter toward the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    // Table index: word-address bits directly above the byte offset.
    function automatic logic [MAX_XLEN-1:0] idx_of(input logic [MAX_XLEN-1:0] pc, input int idx_w);
        logic [MAX_XLEN-1:0] mask;
        mask = (MAX_XLEN'(1) << idx_w) - MAX_XLEN'(1);
        return (pc >> 2) & mask;
    endfunction

    // Tag: every PC bit above the index.
    function automatic logic [MAX_XLEN-1:0] tag_of(input logic [MAX_XLEN-1:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_sat_counter_array.sv
`default_nettype none
// ============================================================================
//  Module      : btb_sat_counter_array
//  Description : ENTRIES x 2-bit direction counter storage. Two asynchronous
//                read ports (fetch lookup, update lookup) and one synchronous
//                write port. Counters reset to weakly-not-taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_sat_counter_array
    import btb_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd0_idx,
    output logic [1:0]       rd0_ctr,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic [1:0]       rd1_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_ctr
);

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    assign rd0_ctr = ctr_q[rd0_idx];
    assign rd1_ctr = ctr_q[rd1_idx];

    // Next-state: only the addressed counter changes on a write.
    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = wr_ctr;
        end
    end

    // Counter storage with asynchronous clear to weakly-not-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : btb_predictor
//  Description : Direct-mapped tagged branch target buffer with 2-bit
//                saturating direction counters. Combinational lookup for IF,
//                single registered update port from EX, misprediction count.
//                Optional gshare counter indexing: define BTB_GSHARE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor
    import btb_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int ENTRIES = 32,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_next_pc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_taken,
    input  logic             upd_is_jump,
`ifdef BTB_GSHARE_EN
    output logic [IDX_W-1:0] pred_ghr,
    input  logic [IDX_W-1:0] upd_ghr,
`endif
    output logic [31:0]      mispredict_cnt
);

    // Table state (counters live in the sub-module)
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic [31:0]      cnt_q;
    logic [31:0]      cnt_d;

    logic [IDX_W-1:0] w_f_idx, w_u_idx, w_f_cidx, w_u_cidx;
    logic [TAG_W-1:0] w_f_tag, w_u_tag;
    logic [1:0]       w_f_ctr, w_u_ctr, w_ctr_wdata;
    logic             w_ctr_we;
    logic             w_u_hit, w_u_pred_taken, w_mispredict;

    assign w_f_idx = IDX_W'(idx_of(MAX_XLEN'(fetch_pc), IDX_W));
    assign w_f_tag = TAG_W'(tag_of(MAX_XLEN'(fetch_pc), IDX_W));
    assign w_u_idx = IDX_W'(idx_of(MAX_XLEN'(upd_pc), IDX_W));
    assign w_u_tag = TAG_W'(tag_of(MAX_XLEN'(upd_pc), IDX_W));

`ifdef BTB_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    // Counters are hashed with history; tag/target/valid stay PC-indexed.
    assign w_f_cidx = w_f_idx ^ ghr_q;
    assign w_u_cidx = w_u_idx ^ upd_ghr;
    assign pred_ghr = ghr_q;

    // History shifts in resolved conditional-branch outcomes only.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && !upd_is_jump) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign w_f_cidx = w_f_idx;
    assign w_u_cidx = w_u_idx;
`endif

    btb_sat_counter_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_ctr_array (
        .clk     (clk),
        .reset   (reset),
        .rd0_idx (w_f_cidx),
        .rd0_ctr (w_f_ctr),
        .rd1_idx (w_u_cidx),
        .rd1_ctr (w_u_ctr),
        .wr_en   (w_ctr_we),
        .wr_idx  (w_u_cidx),
        .wr_ctr  (w_ctr_wdata)
    );

    // Fetch lookup sees pre-edge state, so a same-cycle update is not visible.
    assign pred_hit     = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
    assign pred_taken   = pred_hit && w_f_ctr[1];
    assign pred_next_pc = pred_taken ? target_q[w_f_idx] : fetch_pc + XLEN'(4);

    // Prediction the table would have given the resolving instruction.
    assign w_u_hit        = valid_q[w_u_idx] && (tag_q[w_u_idx] == w_u_tag);
    assign w_u_pred_taken = w_u_hit && w_u_ctr[1];
    assign w_mispredict   = upd_valid &&
                            ((w_u_pred_taken != upd_taken) ||
                             (w_u_pred_taken && upd_taken && (target_q[w_u_idx] != upd_target)));

    // Update: train on hit, allocate only on a taken miss.
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        w_ctr_we    = 1'b0;
        w_ctr_wdata = w_u_ctr;
        if (upd_valid) begin
            if (w_u_hit) begin
                target_d[w_u_idx] = upd_target;
                w_ctr_we          = 1'b1;
                w_ctr_wdata       = upd_is_jump ? ST : sat_update(w_u_ctr, upd_taken);
            end else if (upd_taken) begin
                valid_d[w_u_idx]  = 1'b1;
                tag_d[w_u_idx]    = w_u_tag;
                target_d[w_u_idx] = upd_target;
                w_ctr_we          = 1'b1;
                w_ctr_wdata       = upd_is_jump ? ST : WT;
            end
        end
    end

    // Misprediction count wraps naturally at 2^32.
    always_comb begin
        cnt_d = cnt_q + {31'b0, w_mispredict};
    end

    // Valid/tag/target storage and counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_predictor
//  Description : Directed self-checking bench for btb_predictor with a
//                PC-level reference model and per-cycle output comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_predictor;

    localparam int ENTRIES = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_pc = 32'h100;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_is_jump = 1'b0;
    logic [31:0] mispredict_cnt;
`ifdef BTB_GSHARE_EN
    logic [$clog2(ENTRIES)-1:0] pred_ghr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btb_predictor #(
        .XLEN    (32),
        .ENTRIES (ENTRIES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
`ifdef BTB_GSHARE_EN
        .pred_ghr       (pred_ghr),
        .upd_ghr        (pred_ghr),
`endif
        .mispredict_cnt (mispredict_cnt)
    );

    // ---------------- reference model (plain PC arithmetic) ----------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_cnt;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_ptaken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k]  <= 1'b0;
                m_tag[k]    <= '0;
                m_target[k] <= '0;
                m_ctr[k]    <= 1;
            end
            m_cnt <= '0;
        end else if (upd_valid) begin
            if ((m_ptaken(upd_pc) != upd_taken) ||
                (m_ptaken(upd_pc) && upd_taken && (m_target[m_idx(upd_pc)] != upd_target)))
                m_cnt <= m_cnt + 32'd1;
            if (m_hit(upd_pc)) begin
                m_target[m_idx(upd_pc)] <= upd_target;
                if (upd_is_jump)
                    m_ctr[m_idx(upd_pc)] <= 3;
                else if (upd_taken)
                    m_ctr[m_idx(upd_pc)] <= (m_ctr[m_idx(upd_pc)] >= 3) ? 3 : m_ctr[m_idx(upd_pc)] + 1;
                else
                    m_ctr[m_idx(upd_pc)] <= (m_ctr[m_idx(upd_pc)] <= 0) ? 0 : m_ctr[m_idx(upd_pc)] - 1;
            end else if (upd_taken) begin
                m_valid[m_idx(upd_pc)]  <= 1'b1;
                m_tag[m_idx(upd_pc)]    <= m_tagof(upd_pc);
                m_target[m_idx(upd_pc)] <= upd_target;
                m_ctr[m_idx(upd_pc)]    <= upd_is_jump ? 3 : 2;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every cycle, mid-period: outputs must match the model.
    always @(negedge clk) begin
        check("cmp_hit",   {31'b0, pred_hit},   {31'b0, m_hit(fetch_pc)});
        check("cmp_taken", {31'b0, pred_taken}, {31'b0, m_ptaken(fetch_pc)});
        check("cmp_next",  pred_next_pc,        m_next(fetch_pc));
        check("cmp_cnt",   mispredict_cnt,      m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic jp);
        upd_pc      = pc;
        upd_target  = tgt;
        upd_taken   = tk;
        upd_is_jump = jp;
        upd_valid   = 1'b1;
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        look(32'h100);
        check("rst_hit",  {31'b0, pred_hit}, 32'd0);
        check("rst_next", pred_next_pc,      32'h104);
        check("rst_cnt",  mispredict_cnt,    32'd0);

        // Taken miss allocates with weakly-taken counter
        upd(32'h100, 32'h180, 1'b1, 1'b0);
        look(32'h100);
        check("alloc_hit",   {31'b0, pred_hit},   32'd1);
        check("alloc_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc_next",  pred_next_pc,        32'h180);
        check("alloc_cnt",   mispredict_cnt,      32'd1);

        // Two not-taken: 10 -> 01 -> 00
        upd(32'h100, 32'h180, 1'b0, 1'b0);
        upd(32'h100, 32'h180, 1'b0, 1'b0);
        look(32'h100);
        check("nt_hit",   {31'b0, pred_hit},   32'd1);
        check("nt_taken", {31'b0, pred_taken}, 32'd0);
        check("nt_next",  pred_next_pc,        32'h104);
        check("nt_cnt",   mispredict_cnt,      32'd2);
        // One taken: 00 -> 01, still not taken
        upd(32'h100, 32'h180, 1'b1, 1'b0);
        look(32'h100);
        check("t01_taken", {31'b0, pred_taken}, 32'd0);
        check("t01_cnt",   mispredict_cnt,      32'd3);

        // Alias: 0x180 shares index 0 with 0x100
        upd(32'h100, 32'h180, 1'b1, 1'b0);
        upd(32'h180, 32'h1C0, 1'b1, 1'b0);
        look(32'h100);
        check("alias_old_hit", {31'b0, pred_hit}, 32'd0);
        look(32'h180);
        check("alias_new_hit",  {31'b0, pred_hit}, 32'd1);
        check("alias_new_next", pred_next_pc,      32'h1C0);
        look(32'h182);
        check("lowbits_ignored", pred_next_pc, 32'h1C0);
        check("alias_cnt", mispredict_cnt, 32'd5);

        // Jump allocates strongly taken; one not-taken leaves it taken
        upd(32'h200, 32'h40, 1'b1, 1'b1);
        upd(32'h200, 32'h40, 1'b0, 1'b0);
        look(32'h200);
        check("jal_taken", {31'b0, pred_taken}, 32'd1);
        check("jal_next",  pred_next_pc,        32'h40);
        check("jal_cnt",   mispredict_cnt,      32'd7);

        // Not-taken miss does not allocate
        upd(32'h404, 32'h500, 1'b0, 1'b0);
        look(32'h404);
        check("nt_noalloc", {31'b0, pred_hit}, 32'd0);

        // PC+4 wraps
        look(32'hFFFF_FFFC);
        check("wrap_next", pred_next_pc, 32'h0);

        // Mixed vectors across several indices, checked by the model
        for (int i = 0; i < 8; i++)
            upd(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16), (i % 3) != 0, i == 5);
        for (int i = 0; i < 8; i++)
            upd(32'h1000 + 32'(i * 4), 32'h3000 + 32'(i * 8), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            upd(32'h1000 + 32'(i * 4), 32'h3000 + 32'(i * 8), 1'b0, 1'b0);
            look(32'h1000 + 32'(i * 4));
        end

        // Same-cycle lookup and update see old contents
        @(posedge clk);
        #1;
        look(32'h300);
        upd_pc = 32'h300; upd_target = 32'h340; upd_taken = 1'b1; upd_is_jump = 1'b0;
        upd_valid = 1'b1;
        #1;
        check("same_cycle_old", {31'b0, pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        check("same_cycle_new_hit",  {31'b0, pred_hit}, 32'd1);
        check("same_cycle_new_next", pred_next_pc,      32'h340);

        // Asynchronous reset mid-cycle clears immediately
        reset = 1'b0;
        #1;
        check("async_rst_hit",  {31'b0, pred_hit}, 32'd0);
        check("async_rst_next", pred_next_pc,      32'h304);
        check("async_rst_cnt",  mispredict_cnt,    32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped, tagged branch target buffer with per-entry 2-bit saturating direction counters, for the pipelined RV32I core.
- The IF stage does a combinational lookup on the fetch PC and gets a predicted next PC.
- The EX stage writes back resolved branch/jump outcomes through a single update port.
- Successor to the fixed PC+offset target logic: adds storage, tags, hysteresis and parametrised depth.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 32, number of BTB entries; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width (localparam).
- TAG_W, XLEN-IDX_W-2, tag width (localparam).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears the table.
- fetch_pc  input  XLEN  IF-stage PC to predict.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  hit and counter[1]==1.
- pred_next_pc  output  XLEN  pred_taken ? stored target : fetch_pc+4.
- upd_valid  input  1  EX resolved a control-flow instruction this cycle.
- upd_pc  input  XLEN  PC of the resolved instruction.
- upd_target  input  XLEN  computed target (branch/jal/jalr).
- upd_taken  input  1  actual outcome.
- upd_is_jump  input  1  jal/jalr (unconditional).
- mispredict_cnt  output  32  count of updates whose outcome differed from the prediction made at update time.

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Per entry state: valid (1), tag (TAG_W), target (XLEN), ctr (2).
- Lookup: purely combinational, zero latency.
  - hit = valid[idx] && tag[idx]==fetch_tag.
  - On a miss: pred_taken=0, pred_next_pc=fetch_pc+4 (wraps modulo 2^XLEN).
- Update, registered on the clk edge when upd_valid=1.
  - Tag match and valid:
    - target <= upd_target.
    - ctr saturating: taken -> min(ctr+1,3); not taken -> max(ctr-1,0).
    - upd_is_jump forces ctr <= 2'b11.
  - Miss (invalid entry or tag mismatch):
    - If upd_taken: allocate/replace the entry: valid<=1, tag<=upd tag, target<=upd_target, ctr<= upd_is_jump ? 2'b11 : 2'b10.
    - If not taken: the entry is left untouched; no allocation for not-taken branches.
- Misprediction counter:
  - "Prediction at update time" = the combinational lookup of upd_pc against pre-edge state, computed internally.
  - Mispredict if predicted taken != upd_taken, or both taken and stored target != upd_target.
  - mispredict_cnt increments by 1 per mispredicted update; wraps at 2^32.
- Same-cycle lookup and update to the same index: lookup returns pre-update (old) contents; the new value is visible next cycle.
- Reset (asserted at any time, including mid-update): all valid<=0, ctr<=2'b01, tag/target<=0, mispredict_cnt<=0.
  - Outputs during reset: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4.
- upd_valid=0: no state changes.

Optional Feature:
- Macro: BTB_GSHARE_EN.
- Defined:
  - Internal IDX_W-bit global history register ghr, reset to 0.
  - The counter array is indexed by pc_index XOR ghr; tag/target/valid still use pc_index.
  - Extra ports:
    - pred_ghr (output, IDX_W): current ghr, piped down with the instruction.
    - upd_ghr (input, IDX_W): that snapshot, used for the update counter index.
  - On upd_valid && !upd_is_jump: ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - Mispredict-repair is out of scope; ghr is speculative-free because it is updated from EX only.
- Undefined: no ghr and no extra ports; behaviour is exactly as above.

Decomposition:
- Shared package btb_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - function sat_update(ctr, taken).
  - function idx_of(pc) and tag_of(pc), parametrised by IDX_W.
- One sub-module, btb_sat_counter_array: ENTRIES x 2-bit counter storage with async-read and sync-write ports, reused by the gshare variant.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_hit=0, pred_next_pc=0x104, mispredict_cnt=0.
- Update pc=0x100, target=0x180, taken, branch; then fetch 0x100 -> hit=1, taken=1 (ctr=10), next_pc=0x180, mispredict_cnt=1.
- Two not-taken updates on 0x100 (ctr 10->01->00) -> pred_taken=0, next_pc=0x104, hit=1; one taken update -> ctr=01, still not taken.
- Alias with ENTRIES=32: taken update pc=0x100, then taken update pc=0x180 (same index, different tag) -> fetch 0x100 misses, fetch 0x180 hits with the new target.
- jal update pc=0x200, target=0x40 -> ctr=11; a not-taken update is not applied as a jump, so ctr drops to 10 and the prediction stays taken.
- Same cycle: fetch 0x300 with a taken update of 0x300 -> pred_hit=0 that cycle, 1 the next; then reset_n low mid-cycle -> pred_hit drops to 0 immediately.
